// File: rtl/uart_rx.sv
// ============================================================================
//  uart_rx : UART receiver, 2-FF synchronized input, mid-bit sampling,
//            one-cycle rvalid / ferr strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int BAUDRATE = 115200,
  parameter int FREQ     = 50_000_000,
  parameter int N_start  = 1,
  parameter int N_data   = 6,
  parameter int N_stop   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [N_data-1:0] rdata,
  output logic              rvalid,
  output logic              ferr,
  output logic              busy
);

  localparam int unsigned c_T            = FREQ / BAUDRATE;
  localparam logic [31:0] c_START_SAMPLE = 32'(c_T / 2 - 1 + (N_start - 1) * c_T);
  localparam logic [31:0] c_BIT_LAST     = 32'(c_T - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_rxs;
  logic              r_prev;
  logic [31:0]       r_cnt_clk;
  logic [3:0]        r_cnt_bit;
  logic [N_data-1:0] r_shift;
  logic [N_data-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_ferr;
  logic              r_ferr_flag;

  logic w_start_edge;
  logic w_mid_start;
  logic w_tick;
  logic w_last_data;
  logic w_last_stop;
  logic w_frame_bad;

  // A held-low line never looks like an edge, so a break cannot retrigger.
  assign w_start_edge = r_prev & ~r_rxs;
  assign w_mid_start  = (r_cnt_clk == c_START_SAMPLE);
  assign w_tick       = (r_cnt_clk == c_BIT_LAST);
  assign w_last_data  = w_tick && (r_cnt_bit == 4'(N_data - 1));
  assign w_last_stop  = w_tick && (r_cnt_bit == 4'(N_stop - 1));
  assign w_frame_bad  = r_ferr_flag | ~r_rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_prev  <= r_rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next = S_START;
      S_START: if (w_mid_start)  w_next = r_rxs ? S_IDLE : S_DATA;
      S_DATA:  if (w_last_data)  w_next = S_STOP;
      S_STOP:  if (w_last_stop)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_clk   <= '0;
      r_cnt_bit   <= '0;
      r_shift     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_ferr      <= 1'b0;
      r_ferr_flag <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt_clk   <= '0;
          r_cnt_bit   <= '0;
          r_ferr_flag <= 1'b0;
        end
        S_START: r_cnt_clk <= w_mid_start ? '0 : r_cnt_clk + 32'd1;
        S_DATA: begin
          if (w_tick) begin
            for (int i = 0; i < N_data; i++)
              if (r_cnt_bit == 4'(i)) r_shift[i] <= r_rxs;
            r_cnt_clk <= '0;
            r_cnt_bit <= w_last_data ? 4'd0 : r_cnt_bit + 4'd1;
          end else begin
            r_cnt_clk <= r_cnt_clk + 32'd1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt_clk <= '0;
            r_cnt_bit <= r_cnt_bit + 4'd1;
            if (!r_rxs) r_ferr_flag <= 1'b1;
            // Last stop sample lands mid-bit, leaving half a bit to catch the next edge.
            if (w_last_stop) begin
              if (w_frame_bad) begin
                r_ferr <= 1'b1;
              end else begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_shift;
              end
            end
          end else begin
            r_cnt_clk <= r_cnt_clk + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign ferr   = r_ferr;
  assign busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  tb_uart_rx : directed, table-driven bench for uart_rx (T=16, 6N1 and 8N2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx6, rx8;
  logic [5:0] rdata6;
  logic       rvalid6, ferr6, busy6;
  logic [7:0] rdata8;
  logic       rvalid8, ferr8, busy8;

  uart_rx #(.BAUDRATE(1), .FREQ(16), .N_start(1), .N_data(6), .N_stop(1)) dut6 (
    .clk(clk), .rst(rst), .rx(rx6),
    .rdata(rdata6), .rvalid(rvalid6), .ferr(ferr6), .busy(busy6)
  );

  uart_rx #(.BAUDRATE(1), .FREQ(16), .N_start(1), .N_data(8), .N_stop(2)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8),
    .rdata(rdata8), .rvalid(rvalid8), .ferr(ferr8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nv6 = 0, nf6 = 0, pc6 = 0, nv8 = 0, nf8 = 0, pc8 = 0;
  always @(negedge clk) begin
    if (rvalid6) begin nv6 <= nv6 + 1; pc6 <= cyc; end
    if (ferr6)   begin nf6 <= nf6 + 1; pc6 <= cyc; end
    if (rvalid8) begin nv8 <= nv8 + 1; pc8 <= cyc; end
    if (ferr8)   begin nf8 <= nf8 + 1; pc8 <= cyc; end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit sel8, input logic v);
    if (sel8) rx8 = v;
    else      rx6 = v;
  endtask

  // One clock: change rx just after the rising edge, return on the falling edge.
  task automatic tick(input bit sel8, input logic v);
    @(posedge clk);
    #1;
    drive(sel8, v);
    @(negedge clk);
  endtask

  // Sends one frame (stop_bad bit j forces stop bit j low), then gap idle bits.
  task automatic send_frame(input bit sel8, input logic [7:0] data, input logic [1:0] stop_bad,
                            input int gap, output int c0, output int s_exp);
    int nd, ns, len, b, busy_bad;
    logic v, bz;
    nd = sel8 ? 8 : 6;
    ns = sel8 ? 2 : 1;
    len = 1 + nd + ns;
    s_exp = T / 2 + (nd + ns) * T;
    busy_bad = 0;
    c0 = 0;
    for (int i = 0; i < len * T; i++) begin
      b = i / T;
      if (b == 0)       v = 1'b0;
      else if (b <= nd) v = data[b-1];
      else              v = ~stop_bad[b-1-nd];
      @(posedge clk);
      #1;
      if (i == 0) c0 = cyc;
      drive(sel8, v);
      @(negedge clk);
      bz = sel8 ? busy8 : busy6;
      if (i >= 3 && i <= s_exp + 2 && bz !== 1'b1) busy_bad++;
      if (i == s_exp + 3 && bz !== 1'b0) busy_bad++;
    end
    for (int i = 0; i < gap * T; i++) tick(sel8, 1'b1);
    chk(sel8 ? "busy_window8" : "busy_window6", busy_bad, 0);
  endtask

  typedef struct {
    bit         sel8;
    logic [7:0] data;
    logic [1:0] stop_bad;
    int         gap;
    int         dv;
    int         df;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c0, s_exp, v0, f0, hold_bad;
    logic b5, b20;

    vecs[0] = '{1'b0, 8'h2D, 2'b00, 0, 1, 0, 8'h2D};
    vecs[1] = '{1'b0, 8'h00, 2'b00, 0, 1, 0, 8'h00};
    vecs[2] = '{1'b0, 8'h3F, 2'b00, 0, 1, 0, 8'h3F};
    vecs[3] = '{1'b0, 8'h15, 2'b00, 0, 1, 0, 8'h15};
    vecs[4] = '{1'b0, 8'h2A, 2'b00, 0, 1, 0, 8'h2A};
    vecs[5] = '{1'b0, 8'h12, 2'b01, 1, 0, 1, 8'h2A};
    vecs[6] = '{1'b1, 8'hA5, 2'b10, 1, 0, 1, 8'h00};
    vecs[7] = '{1'b1, 8'hA5, 2'b00, 0, 1, 0, 8'hA5};

    rst = 1'b1;
    rx6 = 1'b1;
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rdata6", rdata6, 0);
    chk("reset_rvalid6", rvalid6, 0);
    chk("reset_ferr6", ferr6, 0);
    chk("reset_busy6", busy6, 0);
    chk("reset_rdata8", rdata8, 0);
    chk("reset_busy8", busy8, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick(1'b0, 1'b1);

    // Table: vectors 0..4 are back-to-back on the 6N1 receiver.
    for (int k = 0; k < 8; k++) begin
      v0 = vecs[k].sel8 ? nv8 : nv6;
      f0 = vecs[k].sel8 ? nf8 : nf6;
      send_frame(vecs[k].sel8, vecs[k].data, vecs[k].stop_bad, vecs[k].gap, c0, s_exp);
      if (vecs[k].sel8) begin
        chk($sformatf("v%0d_rvalid_cnt", k), nv8 - v0, vecs[k].dv);
        chk($sformatf("v%0d_ferr_cnt", k), nf8 - f0, vecs[k].df);
        chk($sformatf("v%0d_rdata", k), rdata8, vecs[k].exp_rdata);
        chk($sformatf("v%0d_pulse_cycle", k), pc8, c0 + s_exp + 3);
      end else begin
        chk($sformatf("v%0d_rvalid_cnt", k), nv6 - v0, vecs[k].dv);
        chk($sformatf("v%0d_ferr_cnt", k), nf6 - f0, vecs[k].df);
        chk($sformatf("v%0d_rdata", k), rdata6, vecs[k].exp_rdata[5:0]);
        chk($sformatf("v%0d_pulse_cycle", k), pc6, c0 + s_exp + 3);
      end
    end

    // Glitch: 4 clocks low is rejected at the mid-start sample.
    v0 = nv6; f0 = nf6; b5 = 1'b0; b20 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, (i < 4) ? 1'b0 : 1'b1);
      if (i == 5)  b5 = busy6;
      if (i == 20) b20 = busy6;
    end
    chk("glitch_busy_started", b5, 1);
    chk("glitch_back_idle", b20, 0);
    chk("glitch_rvalid_cnt", nv6 - v0, 0);
    chk("glitch_ferr_cnt", nf6 - f0, 0);
    chk("glitch_rdata", rdata6, 6'h2A);

    // Break: bad stop then line held low for 3 bit times, no retrigger.
    v0 = nv6; f0 = nf6; hold_bad = 0;
    send_frame(1'b0, 8'h12, 2'b01, 0, c0, s_exp);
    for (int i = 0; i < 3 * T; i++) begin
      tick(1'b0, 1'b0);
      if (busy6 !== 1'b0) hold_bad++;
    end
    chk("break_ferr_cnt", nf6 - f0, 1);
    chk("break_rvalid_cnt", nv6 - v0, 0);
    chk("break_rdata", rdata6, 6'h2A);
    chk("break_no_retrigger", hold_bad, 0);
    repeat (T) tick(1'b0, 1'b1);
    v0 = nv6;
    send_frame(1'b0, 8'h33, 2'b00, 0, c0, s_exp);
    chk("rearm_rvalid_cnt", nv6 - v0, 1);
    chk("rearm_rdata", rdata6, 6'h33);

    // Reset during data bit 3 of 6'h38; remaining bits and stop are high.
    v0 = nv6; f0 = nf6;
    for (int i = 0; i < 8 * T; i++) begin
      @(posedge clk);
      #1;
      drive(1'b0, (i < T) ? 1'b0 : (((8'h38 >> ((i / T) - 1)) & 8'h01) != 0 || i >= 7 * T));
      if (i == 70) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_async_rdata6", rdata6, 0);
        chk("rst_async_busy6", busy6, 0);
        chk("rst_async_rdata8", rdata8, 0);
      end
      if (i == 71) rst = 1'b0;
      @(negedge clk);
    end
    chk("rst_no_rvalid", nv6 - v0, 0);
    chk("rst_no_ferr", nf6 - f0, 0);
    v0 = nv6;
    send_frame(1'b0, 8'h07, 2'b00, 0, c0, s_exp);
    chk("post_rst_rvalid_cnt", nv6 - v0, 1);
    chk("post_rst_rdata", rdata6, 6'h07);
    chk("post_rst_pulse_cycle", pc6, c0 + s_exp + 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's `uart_tx`. It deserializes an asynchronous serial line into N_data-bit words and uses the same frame format and baud arithmetic as the transmitter, so the two can be looped back directly. It sits between the off-chip serial RX pin and the ADC control/readback logic. Each received word is presented with a one-cycle valid strobe, and a framing-error strobe flags a bad stop bit.

## Interface
- BAUDRATE, 115200: line bit rate.
- FREQ, 50_000_000: clk frequency in Hz. T = FREQ/BAUDRATE (integer division) clocks per bit; T ≥ 4 required.
- N_start, 1: start bits per frame (1 supported).
- N_data, 6: data bits per frame, sent LSB first; range 1..8.
- N_stop, 1: stop bits per frame; range 1..2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high. One clock domain only.
- rx  in  1  serial input. Asynchronous to clk; idles high.
- rdata  out  N_data  last correctly received word. Held until the next good frame.
- rvalid  out  1  one-cycle pulse; rdata is new in the same cycle.
- ferr  out  1  one-cycle pulse on a framing error (stop bit sampled low).
- busy  out  1  high while a frame is being received (state ≠ IDLE).

## Operation
- Input conditioning
  - rx passes through a 2-FF synchronizer; the synchronized value is called rxs.
  - A third register holds the previous rxs value.
  - A start edge is rxs falling, i.e. prev=1 and rxs=0.
  - Synchronizer flops reset to 1.
- FSM states: IDLE, START, DATA, STOP. The encoding is 2 bits.
- Counters
  - cnt_clk: 32-bit clock counter.
  - cnt_bit: 4-bit bit counter.
  - Shift register: N_data bits.
- IDLE
  - Counters are held at 0.
  - On a start edge, go to START.
- START
  - cnt_clk counts up. When cnt_clk = T/2−1, the start bit is sampled at mid-bit:
    - rxs=0: go to DATA and clear cnt_clk.
    - rxs=1: false start (glitch). Return to IDLE with no strobe.
- DATA
  - cnt_clk counts 0..T−1. At T−1, rxs is sampled into shift-register bit position cnt_bit (LSB first), cnt_bit increments and cnt_clk clears.
  - After N_data samples, clear cnt_bit and go to STOP.
- STOP
  - Sampling uses the same T−1 cadence as DATA, N_stop times.
  - Any stop sample equal to 0 latches a frame-error flag for the current frame.
  - At the last stop sample, return to IDLE. This happens at mid-stop-bit, so a following start edge is caught.
  - Flag clear: rdata ← shift register and pulse rvalid.
  - Flag set: pulse ferr; rdata is unchanged.
- After ferr, a line held low (break) does not retrigger. Re-arming requires rxs to return high and then fall again.
- rx activity while not in IDLE does not restart the frame.
- rst mid-frame: everything returns immediately to reset values and the partial word is discarded. After rst is released, a frame already in progress on the line is ignored until a clean falling edge.

## Timing
- Reset values:
  - rdata=0, rvalid=0, ferr=0, busy=0.
  - State IDLE, counters 0, synchronizer and prev registers 1.
- Input latency: 2 clk from an rx edge to rxs.
- Sample points, counted in clk from the clock where the start edge is detected on rxs:
  - Start bit: at T/2.
  - Data bit k (k=0..N_data−1): at T/2 + (k+1)·T.
  - Stop bit j (j=0..N_stop−1): at T/2 + (N_data+1+j)·T.
- rvalid/ferr rise in the cycle after the final stop sample and are exactly 1 clk wide. rdata updates in that same cycle.
- busy goes high the cycle after the start edge and low in the same cycle rvalid/ferr rise.
- Back-to-back frames (next start bit immediately after the stop bit) are received with no loss. Minimum idle gap is 0 bit times.
- Baud tolerance: sampling at mid-bit gives ±~4% cumulative clock mismatch over a 10-bit frame.

## Test plan
- Single frame, FREQ=16, BAUDRATE=1 (T=16), N_data=6:
  - Drive start bit, then 6'b101101 LSB first, then stop.
  - Required: rdata=6'h2D and rvalid pulse 1 clk wide exactly at the stop-sample+1 cycle.
  - Required: busy high for the whole frame; ferr stays 0.
- Loopback against `uart_tx` (same parameters):
  - Send 0x00, 0x3F, 0x15, 0x2A back-to-back.
  - Required: four rvalid pulses in order, with matching rdata, no ferr.
- Glitch, T=16:
  - Pull rx low for 4 clk, then high.
  - Required: FSM returns to IDLE after the mid-start sample; no rvalid/ferr; rdata unchanged.
- Framing error:
  - Send 6'h12 with the stop bit driven 0, then hold rx low for 3 bit times.
  - Required: one ferr pulse, no rvalid, rdata keeps its previous value, no retrigger until rx rises and falls again.
- Reset mid-frame:
  - Assert rst during data bit 3 for 1 clk.
  - Required: all outputs go to 0 asynchronously, and a clean following frame 6'h07 is received correctly.
- N_stop=2, N_data=8:
  - Send 0xA5 with the second stop bit 0. Required: ferr.
  - Send 0xA5 with a correct frame. Required: rdata=8'hA5 and rvalid.
